// File: rtl/cfg_port_arbiter.sv
// cfg_port_arbiter: round-robin arbiter sharing one config port among NUM_MASTERS masters
//   clk_i, rst_i                   clock, synchronous active-high reset
//   m_req_i/m_lock_i/m_wen_i       per-master request, grant lock, wen (1=read)
//   m_addr_i/m_wdata_i             per-master address and write data, packed by master index
//   m_gnt_o/m_rvalid_o/m_rdata_o   one-hot grant, one-hot read-valid, shared read data
//   cfg_req_o/cfg_gnt_i            request/grant towards the config unit
//   cfg_wen_o/cfg_addr_o/cfg_wdata_o  forwarded winner command
//   cfg_rdata_i/cfg_rvalid_i       read response from the config unit
//   err_o                          sticky: read response with no outstanding read
module cfg_port_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS-1:0]            m_req_i,
    input  logic [NUM_MASTERS-1:0]            m_lock_i,
    input  logic [NUM_MASTERS-1:0]            m_wen_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]            m_gnt_o,
    output logic [DATA_WIDTH-1:0]             m_rdata_o,
    output logic [NUM_MASTERS-1:0]            m_rvalid_o,
    output logic                              cfg_req_o,
    input  logic                              cfg_gnt_i,
    output logic                              cfg_wen_o,
    output logic [ADDR_WIDTH-1:0]             cfg_addr_o,
    output logic [DATA_WIDTH-1:0]             cfg_wdata_o,
    input  logic [DATA_WIDTH-1:0]             cfg_rdata_i,
    input  logic                              cfg_rvalid_i,
    output logic                              err_o
);
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [IW-1:0] rr_q, win, win_nxt, cand;
    logic          lock_q, found, stall, hs, push, pop;
    logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return p == PW'(MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
    endfunction

    // A lock parks rr_q on the locked master, so scanning from rr_q already
    // gives it priority while it keeps requesting.
    always_comb begin
        win   = rr_q;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = IW'((int'(rr_q) + k) % NUM_MASTERS);
            if (!found && m_req_i[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    assign win_nxt     = win == IW'(NUM_MASTERS - 1) ? '0 : win + 1'b1;
    // A pop in the same cycle does not lift the stall, keeping the path from rvalid to req short.
    assign stall       = cnt_q == CW'(MAX_OUTSTANDING);
    assign cfg_req_o   = !rst_i && |m_req_i && !stall;
    assign cfg_wen_o   = cfg_req_o && m_wen_i[win];
    assign cfg_addr_o  = cfg_req_o ? m_addr_i[win*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign cfg_wdata_o = cfg_req_o ? m_wdata_i[win*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign hs          = cfg_req_o && cfg_gnt_i;
    assign m_gnt_o     = hs ? NUM_MASTERS'(1) << win : '0;
    assign push        = hs && cfg_wen_o;
    assign pop         = !rst_i && cfg_rvalid_i && cnt_q != '0;
    assign m_rvalid_o  = pop ? NUM_MASTERS'(1) << fifo_q[rd_q] : '0;
    assign m_rdata_o   = cfg_rdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            err_o  <= 1'b0;
        end else begin
            if (hs) begin
                lock_q <= m_lock_i[win];
                rr_q   <= m_lock_i[win] ? win : win_nxt;
            end else if (lock_q && !m_req_i[rr_q]) begin
                lock_q <= 1'b0;
            end
            if (push) wr_q <= ptr_inc(wr_q);
            if (pop) rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            if (cfg_rvalid_i && cnt_q == '0) err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_q] <= win;
    end
endmodule

// File: tb/tb_cfg_port_arbiter.sv
// tb_cfg_port_arbiter: scoreboard bench for cfg_port_arbiter with a config-unit response model
module tb_cfg_port_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  m_req = '0, m_lock = '0, m_wen = '0;
    logic [31:0] m_addr = '0;
    logic [63:0] m_wdata = '0;
    logic        cfg_gnt = 1'b1, rv = 1'b0, stray = 1'b0, sel1 = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  gnt0, gnt1, rvo0, rvo1;
    logic [31:0] rdo0, rdo1, wd0, wd1;
    logic [15:0] addr0, addr1;
    logic        req0, req1, wen0, wen1, err0, err1;

    always #5 clk = ~clk;

    cfg_port_arbiter dut (
        .clk_i(clk), .rst_i(rst), .m_req_i(m_req), .m_lock_i(m_lock), .m_wen_i(m_wen),
        .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_gnt_o(gnt0), .m_rdata_o(rdo0),
        .m_rvalid_o(rvo0), .cfg_req_o(req0), .cfg_gnt_i(cfg_gnt), .cfg_wen_o(wen0),
        .cfg_addr_o(addr0), .cfg_wdata_o(wd0), .cfg_rdata_i(rdata),
        .cfg_rvalid_i(rv | stray), .err_o(err0)
    );

    cfg_port_arbiter #(.MAX_OUTSTANDING(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .m_req_i(m_req), .m_lock_i(m_lock), .m_wen_i(m_wen),
        .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_gnt_o(gnt1), .m_rdata_o(rdo1),
        .m_rvalid_o(rvo1), .cfg_req_o(req1), .cfg_gnt_i(cfg_gnt), .cfg_wen_o(wen1),
        .cfg_addr_o(addr1), .cfg_wdata_o(wd1), .cfg_rdata_i(rdata),
        .cfg_rvalid_i(rv | stray), .err_o(err1)
    );

    wire [1:0]  gnt_s  = sel1 ? gnt1 : gnt0;
    wire [1:0]  rvo_s  = sel1 ? rvo1 : rvo0;
    wire [31:0] rdo_s  = sel1 ? rdo1 : rdo0;
    wire [15:0] addr_s = sel1 ? addr1 : addr0;
    wire        req_s  = sel1 ? req1 : req0;
    wire        wen_s  = sel1 ? wen1 : wen0;

    typedef struct { int due; logic [31:0] d; } rsp_t;
    typedef struct { int m; logic [31:0] d; } exp_t;
    rsp_t rsp_q[$];
    exp_t exp_q[$];
    int cyc = 0, rsp_dly = 1, vectors = 0, miscompares = 0;

    function automatic logic [31:0] rsp_data(input logic [15:0] a);
        return a == 16'h1000 ? 32'h0000_0042 : {16'hC0DE, a};
    endfunction

    // Negedge: scoreboard pop on read-valid, then record read handshakes for the response model.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (rvo_s != 2'b00) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_rvalid cyc=%0d: m_rvalid_o=%b, required 00", cyc, rvo_s);
            end else begin
                e = exp_q.pop_front();
                if (rvo_s !== (2'b01 << e.m) || rdo_s !== e.d) begin
                    miscompares++;
                    $display("FAIL rvalid_route cyc=%0d: rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                             cyc, rvo_s, rdo_s, 2'b01 << e.m, e.d);
                end
            end
        end
        if (req_s && cfg_gnt && wen_s) rsp_q.push_back('{cyc + rsp_dly, rsp_data(addr_s)});
    endtask

    task automatic advance();
        rsp_t r;
        @(posedge clk);
        #1;
        cyc++;
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
            r = rsp_q.pop_front();
            rv = 1'b1;
            rdata = r.d;
        end else begin
            rv = 1'b0;
            rdata = $urandom;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_req = '0;
        m_lock = '0;
        sample();
        advance();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && (rsp_q.size() != 0 || rv); i++) begin
            sample();
            advance();
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d responses still expected, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_req = 2'b11;
        m_wen = 2'b11;
        sample();
        vectors += 3;
        if (req0 !== 1'b0) begin miscompares++; $display("FAIL rst_req: %b, required 0", req0); end
        if (gnt0 !== 2'b00) begin miscompares++; $display("FAIL rst_gnt: %b, required 00", gnt0); end
        if (rvo0 !== 2'b00) begin miscompares++; $display("FAIL rst_rvalid: %b, required 00", rvo0); end
        advance();
        rst = 1'b0;
        m_req = '0;
        sample();
        vectors += 3;
        if (err0 !== 1'b0) begin miscompares++; $display("FAIL rst_err: %b, required 0", err0); end
        if (req0 !== 1'b0) begin miscompares++; $display("FAIL idle_req: %b, required 0", req0); end
        if (gnt0 !== 2'b00) begin miscompares++; $display("FAIL idle_gnt: %b, required 00", gnt0); end
        advance();
    endtask

    task automatic test_single_read();
        m_addr[15:0] = 16'h1000;
        m_wen = 2'b01;
        m_req = 2'b01;
        sample();
        vectors += 3;
        if (gnt0 !== 2'b01) begin miscompares++; $display("FAIL rd_gnt: %b, required 01", gnt0); end
        if (wen0 !== 1'b1) begin miscompares++; $display("FAIL rd_wen: %b, required 1", wen0); end
        if (addr0 !== 16'h1000) begin miscompares++; $display("FAIL rd_addr: %h, required 1000", addr0); end
        exp_q.push_back('{0, 32'h0000_0042});
        advance();
        m_req = '0;
        sample();
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL rd_rvalid_next: no response, required rvalid=01"); end
        advance();
        drain();
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        do_reset();
        m_addr = {16'h1020, 16'h1010};
        m_wen = 2'b11;
        m_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            sample();
            g = 2'b01 << (k % 2);
            vectors++;
            if (gnt0 !== g) begin miscompares++; $display("FAIL rr_gnt[%0d]: %b, required %b", k, gnt0, g); end
            exp_q.push_back('{k % 2, rsp_data(k % 2 == 1 ? 16'h1020 : 16'h1010)});
            advance();
        end
        m_req = '0;
        drain();
    endtask

    task automatic test_lock();
        do_reset();
        m_wen = 2'b00;
        m_addr = {16'h3000, 16'h2000};
        m_wdata = {32'h1111_0000, 32'h2222_0000};
        m_lock = 2'b10;
        m_req = 2'b10;
        for (int k = 0; k < 4; k++) begin
            m_wdata[63:32] = 32'h1111_0000 + k;
            if (k > 0) m_req = 2'b11;
            sample();
            vectors += 2;
            if (gnt0 !== 2'b10) begin miscompares++; $display("FAIL lock_gnt[%0d]: %b, required 10", k, gnt0); end
            if (wd0 !== 32'h1111_0000 + k) begin miscompares++; $display("FAIL lock_wdata[%0d]: %h, required %h", k, wd0, 32'h1111_0000 + k); end
            advance();
        end
        m_lock = 2'b00;
        m_req = 2'b01;
        sample();
        vectors += 2;
        if (gnt0 !== 2'b01) begin miscompares++; $display("FAIL unlock_gnt: %b, required 01", gnt0); end
        if (wd0 !== 32'h2222_0000) begin miscompares++; $display("FAIL unlock_wdata: %h, required 22220000", wd0); end
        advance();
        m_req = '0;
        drain();
    endtask

    task automatic test_write();
        do_reset();
        m_addr[15:0] = 16'h2004;
        m_wdata[31:0] = 32'hDEAD_BEEF;
        m_wen = 2'b00;
        m_req = 2'b01;
        sample();
        vectors += 4;
        if (gnt0 !== 2'b01) begin miscompares++; $display("FAIL wr_gnt: %b, required 01", gnt0); end
        if (wen0 !== 1'b0) begin miscompares++; $display("FAIL wr_wen: %b, required 0", wen0); end
        if (wd0 !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_wdata: %h, required deadbeef", wd0); end
        if (addr0 !== 16'h2004) begin miscompares++; $display("FAIL wr_addr: %h, required 2004", addr0); end
        advance();
        m_req = '0;
        sample();
        vectors += 2;
        if (gnt0 !== 2'b00) begin miscompares++; $display("FAIL wr_gnt_pulse: %b, required 00", gnt0); end
        if (wd0 !== 32'h0) begin miscompares++; $display("FAIL idle_wdata: %h, required 0", wd0); end
        advance();
        stray = 1'b1;
        sample();
        vectors += 2;
        if (rvo0 !== 2'b00) begin miscompares++; $display("FAIL wr_no_push: rvalid=%b, required 00", rvo0); end
        if (err0 !== 1'b0) begin miscompares++; $display("FAIL err_early: %b, required 0", err0); end
        advance();
        stray = 1'b0;
        sample();
        vectors++;
        if (err0 !== 1'b1) begin miscompares++; $display("FAIL stray_err: %b, required 1", err0); end
        advance();
    endtask

    task automatic test_max_outstanding();
        logic [4:0] exp_req;
        exp_req = 5'b10001;
        sel1 = 1'b1;
        do_reset();
        rsp_dly = 3;
        m_addr[15:0] = 16'h1000;
        m_wen = 2'b01;
        m_req = 2'b01;
        for (int k = 0; k < 5; k++) begin
            sample();
            vectors += 2;
            if (req_s !== exp_req[k]) begin miscompares++; $display("FAIL stall_req[%0d]: %b, required %b", k, req_s, exp_req[k]); end
            if (gnt_s !== {1'b0, exp_req[k]}) begin miscompares++; $display("FAIL stall_gnt[%0d]: %b, required 0%b", k, gnt_s, exp_req[k]); end
            if (exp_req[k]) exp_q.push_back('{0, 32'h0000_0042});
            advance();
        end
        m_req = '0;
        drain();
        rsp_dly = 1;
        sel1 = 1'b0;
    endtask

    task automatic test_reset_outstanding();
        logic seen;
        do_reset();
        rsp_dly = 4;
        m_addr = {16'h1020, 16'h1010};
        m_wen = 2'b11;
        m_req = 2'b11;
        for (int k = 0; k < 2; k++) begin
            sample();
            advance();
        end
        m_req = '0;
        rst = 1'b1;
        sample();
        advance();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            sample();
            vectors += 2;
            if (rvo0 !== 2'b00) begin miscompares++; $display("FAIL lost_rvalid[%0d]: %b, required 00", k, rvo0); end
            if (err0 !== seen) begin miscompares++; $display("FAIL lost_err[%0d]: %b, required %b", k, err0, seen); end
            seen |= rv;
            advance();
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL lost_stray: no stray response seen, required 1"); end
        rsp_dly = 1;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_write();
        test_max_outstanding();
        test_reset_outstanding();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, required completion");
        $fatal(1);
    end
endmodule
